game_cont_txt_writer: RTL and testbench

GAME_CONT_TXT_WRITER -- requirements
Module: game_cont_txt_writer

---
 rtl/game_txt_pkg.sv | 26 ++
 rtl/game_txt_msg_rom.sv | 38 +++
 rtl/game_cont_txt_writer.sv | 190 +++++++++++++++++++
 tb/tb_game_cont_txt_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_txt_pkg.sv
// Shared types and constants for the dialog text writer: FSM state encoding,
// special character codes and the size of the character grid.
package game_txt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_TYPE     = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam logic [6:0] CHAR_SPACE  = 7'h20;
  localparam logic [6:0] CHAR_END    = 7'h00;
  localparam logic [6:0] CHAR_CURSOR = 7'h5F;
  localparam int         CELLS       = 256;

  localparam int KEY_START = 0;
  localparam int KEY_SKIP  = 1;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_txt_msg_rom.sv
// Synchronous dialog message ROM: {page, cell} -> 7-bit character code, 1 clk latency.
// Page 0 reads "HI" followed by the end marker; later pages fill all 256 cells.
module game_txt_msg_rom
  import game_txt_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int PW        = 2
) (
  input  logic          clk_i,
  input  logic [PW-1:0] page_i,
  input  logic [7:0]    cell_i,
  output logic [6:0]    code_o
);

  logic [6:0] code_q;

  // Pages past 0 cycle through printable ASCII (0x21..0x7E), never the end marker.
  function automatic logic [6:0] msg_code(input logic [PW-1:0] p, input logic [7:0] c);
    int v;
    if (p == '0) begin
      case (c)
        8'd0:    msg_code = 7'h48;
        8'd1:    msg_code = 7'h49;
        default: msg_code = CHAR_END;
      endcase
    end else begin
      v = 33 + ((int'(c) + 7 * int'(p)) % 94);
      msg_code = 7'(v);
    end
  endfunction

  always_ff @(posedge clk_i) begin
    code_q <= msg_code(page_i, cell_i);
  end

  assign code_o = code_q;

endmodule

// File: rtl/game_cont_txt_writer.sv
// Typewriter-style dialog writer: clears a 16x16 char RAM, then types one ROM
// page into it at CHAR_PERIOD pace (or one char/clk after skip). Optional
// blinking cursor on the typing position: define GAME_TXT_CURSOR_EN.
//
// Handshake: key[0]/key[1] are level inputs; only a registered 0->1 transition
// counts as a press, and presses held across reset are not seen as new presses.
module game_cont_txt_writer
  import game_txt_pkg::*;
#(
  parameter int CHAR_PERIOD = 1_000_000,
  parameter int NUM_PAGES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  output logic       busy,
  output logic       page_done,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int             PW        = idx_width(NUM_PAGES);
  localparam int             CW        = $clog2(CHAR_PERIOD);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CHAR_PERIOD - 1);
  localparam logic [PW-1:0]  PAGE_LAST = PW'(NUM_PAGES - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] page_q, page_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fast_q, fast_d;

  logic [1:0]    key_q, key_prev_q, key_vld_q;
  logic [1:0]    key_rise;
  logic          start_edge, skip_edge;
  logic          unused_keys;

  logic          ram_we;
  logic [6:0]    ram_wd;
  logic [6:0]    rom_code;
  logic [6:0]    rd_data;
  logic [6:0]    char_code_q;
  logic [6:0]    ram_q [CELLS];

  assign unused_keys = ^key[3:2];

  // key_vld_q masks the first two samples so a key held through reset is not a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      key_prev_q <= '0;
      key_vld_q  <= '0;
    end else begin
      key_q      <= key[1:0];
      key_prev_q <= key_q;
      key_vld_q  <= {key_vld_q[0], 1'b1};
    end
  end

  assign key_rise   = key_q & ~key_prev_q & {2{key_vld_q[1]}};
  assign start_edge = key_rise[KEY_START];
  assign skip_edge  = key_rise[KEY_SKIP];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      page_q   <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      fast_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      fast_q   <= fast_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    page_d   = page_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    fast_d   = fast_q;
    ram_we   = 1'b0;
    ram_wd   = CHAR_SPACE;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          page_d   = '0;
          wr_ptr_d = '0;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 8'd1;
        cnt_d    = '0;
        fast_d   = 1'b0;
        if (wr_ptr_q == 8'hFF) state_d = ST_TYPE;
      end
      ST_TYPE: begin
        if (skip_edge) fast_d = 1'b1;
        if (fast_q || cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rom_code == CHAR_END) begin
            state_d = ST_WAIT_KEY;
          end else begin
            ram_we = 1'b1;
            ram_wd = rom_code;
            if (wr_ptr_q == 8'hFF) state_d = ST_WAIT_KEY;
            else                   wr_ptr_d = wr_ptr_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_KEY: begin
        if (start_edge) begin
          if (page_q == PAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            page_d   = page_q + PW'(1);
            wr_ptr_d = '0;
            state_d  = ST_CLEAR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Addressing the ROM with next-state values keeps rom_code aligned to
  // {page_q, wr_ptr_q} every cycle, so fast mode writes back-to-back.
  game_txt_msg_rom #(
    .NUM_PAGES(NUM_PAGES),
    .PW       (PW)
  ) u_msg_rom (
    .clk_i (clk),
    .page_i(page_d),
    .cell_i(wr_ptr_d),
    .code_o(rom_code)
  );

  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram_q[wr_ptr_q] <= ram_wd;
  end

`ifdef GAME_TXT_CURSOR_EN
  localparam int            BW         = $clog2(16 * CHAR_PERIOD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(16 * CHAR_PERIOD - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  always_comb begin
    rd_data = ram_q[char_xy];
    if (state_q == ST_TYPE && char_xy == wr_ptr_q && blink_q) rd_data = CHAR_CURSOR;
  end
`else
  assign rd_data = ram_q[char_xy];
`endif

  always_ff @(posedge clk) begin
    if (rst) char_code_q <= '0;
    else     char_code_q <= rd_data;
  end

  assign char_code = char_code_q;
  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_TYPE);
  assign page_done = (state_q == ST_WAIT_KEY);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_game_cont_txt_writer.sv
// Self-checking bench for game_cont_txt_writer (CHAR_PERIOD=4, NUM_PAGES=2):
// screen reads go through an expected-value queue checked by a monitor.
module tb_game_cont_txt_writer;

  localparam int CP = 4;
  localparam int NP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       busy, page_done, done;
  logic [2:0] unused_state_dbg;

  game_cont_txt_writer #(.CHAR_PERIOD(CP), .NUM_PAGES(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .char_xy  (char_xy),
    .char_code(char_code),
    .busy     (busy),
    .page_done(page_done),
    .done     (done),
    .state_dbg(unused_state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [6:0] exp_q[$];
  logic [7:0] addr_q[$];
  logic       rd_issue = 1'b0;
  logic [6:0] scr [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s: actual=%0d expected within [%0d,%0d]", name, v, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] msg(input int p, input int c);
    if (p == 0) return (c == 0) ? 7'h48 : (c == 1) ? 7'h49 : 7'h00;
    return 7'(33 + (c + 7 * p) % 94);
  endfunction

  function automatic int page_len(input int p);
    for (int c = 0; c < 256; c++) if (msg(p, c) == 7'h00) return c;
    return 256;
  endfunction

  // Cycles from TYPE entry until the page ends at normal speed.
  function automatic int type_cycles(input int p);
    int n;
    n = page_len(p);
    return CP * (n + ((n < 256) ? 1 : 0));
  endfunction

  task automatic model_type_page(input int p);
    for (int c = 0; c < 256; c++) scr[c] = 7'h20;
    for (int c = 0; c < page_len(p); c++) scr[c] = msg(p, c);
  endtask

  // ---------------- monitor ----------------
  logic       mon_pend;
  logic [6:0] mon_e;
  logic [7:0] mon_a;
  initial forever begin
    @(posedge clk);
    mon_pend = rd_issue;
    #1;
    if (mon_pend) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = addr_q.pop_front();
        check($sformatf("char_code[%0d]", mon_a), 32'(char_code), 32'(mon_e));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic read_at(input int c, input int a, input logic [6:0] e);
    to_cyc(c);
    char_xy = 8'(a);
    exp_q.push_back(e);
    addr_q.push_back(8'(a));
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic read_screen(input int n);
    for (int i = 0; i < n + 4; i++) begin
      int a;
      a = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 255 : int'($urandom_range(0, 255));
      @(negedge clk);
      char_xy = 8'(a);
      exp_q.push_back(scr[a]);
      addr_q.push_back(8'(a));
      rd_issue = 1'b1;
    end
    @(negedge clk);
    rd_issue = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] k);
    @(negedge clk);
    key = k;
    repeat (3) @(negedge clk);
    key = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  // Press start and return the cycle at which busy is first seen high.
  task automatic start_page(output int e);
    logic found;
    found = 1'b0;
    e = cyc;
    @(negedge clk);
    key = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) key = 4'b0000;
      if (busy === 1'b1 && !found) begin
        found = 1'b1;
        e = cyc;
      end
    end
    key = 4'b0000;
    check("busy_after_start", 32'(found), 32'd1);
  endtask

  task automatic wait_page_done(input int exp_c, input string name);
    while (page_done !== 1'b1 && cyc < exp_c + 64) @(negedge clk);
    check(name, 32'(cyc), 32'(exp_c));
  endtask

  // Skip (optionally with start) after k characters; returns when page_done is seen.
  task automatic skip_after(input int t, input int k, input logic [3:0] keys, input string name);
    int s0;
    to_cyc(t + CP * k);
    key = keys;
    s0 = cyc + 1;
    repeat (3) @(negedge clk);
    key = 4'b0000;
    while (page_done !== 1'b1 && cyc < s0 + 400) @(negedge clk);
    check_range(name, cyc - s0, (256 - k) - 1, (256 - k) + 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int e, t, k;
    rst = 1'b1;
    key = 4'b0001;
    char_xy = 8'd0;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_page_done", 32'(page_done), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_char_code", 32'(char_code), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("held_key_no_start", 32'(busy), 32'd0);
    key = 4'b0000;
    repeat (3) @(negedge clk);

    // Page 0 at normal speed, with exact write timing at cells 0 and 1.
    start_page(e);
    t = e + 256;
    to_cyc(t - 1);
    check("busy_end_of_clear", 32'(busy), 32'd1);
    read_at(t + 3, 0, 7'h20);
    read_at(t + 4, 0, 7'h48);
    read_at(t + 7, 1, 7'h20);
    read_at(t + 8, 1, 7'h49);
    wait_page_done(t + type_cycles(0), "page0_done_cycle");
    check("page0_busy_low", 32'(busy), 32'd0);
    model_type_page(0);
    read_screen(16);
    press_key(4'b0010);
    check("skip_ignored_in_wait", 32'(page_done), 32'd1);

    // Page 1 at normal speed; start presses in CLEAR and TYPE must be ignored.
    start_page(e);
    t = e + 256;
    to_cyc(e + 20);
    key = 4'b0001;
    repeat (3) @(negedge clk);
    key = 4'b0000;
    to_cyc(t + 50);
    key = 4'b0001;
    repeat (3) @(negedge clk);
    key = 4'b0000;
    wait_page_done(t + type_cycles(1), "page1_done_cycle");
    check("page1_not_done", 32'(done), 32'd0);
    model_type_page(1);
    read_screen(20);
    press_key(4'b0001);
    check("last_page_done", 32'(done), 32'd1);
    check("last_page_busy", 32'(busy), 32'd0);

    // Restart from DONE, then skip partway through page 1.
    start_page(e);
    t = e + 256;
    wait_page_done(t + type_cycles(0), "restart_page0_done_cycle");
    model_type_page(0);
    read_screen(8);
    start_page(e);
    t = e + 256;
    k = int'($urandom_range(3, 12));
    skip_after(t, k, 4'b0010, "skip_fill_latency");
    model_type_page(1);
    read_screen(12);
    press_key(4'b0001);
    check("done_after_skip_page", 32'(done), 32'd1);

    // Simultaneous start+skip in TYPE: fast fill and no page advance.
    start_page(e);
    t = e + 256;
    wait_page_done(t + type_cycles(0), "page0_again_done_cycle");
    start_page(e);
    t = e + 256;
    k = int'($urandom_range(2, 20));
    skip_after(t, k, 4'b0011, "start_skip_fill_latency");
    check("start_skip_page_done", 32'(page_done), 32'd1);
    check("start_skip_not_done", 32'(done), 32'd0);
    model_type_page(1);
    read_screen(12);
    press_key(4'b0001);
    check("start_skip_then_done", 32'(done), 32'd1);

    // Reset pulse mid-TYPE with start held across it.
    start_page(e);
    t = e + 256;
    to_cyc(t + int'($urandom_range(1, 10)));
    rst = 1'b1;
    key = 4'b0001;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_page_done", 32'(page_done), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_char_code", 32'(char_code), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_spurious_start", 32'(busy), 32'd0);
    key = 4'b0000;
    repeat (3) @(negedge clk);
    start_page(e);
    t = e + 256;
    wait_page_done(t + type_cycles(0), "post_rst_page0_done_cycle");
    model_type_page(0);
    read_screen(16);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
